// File: rtl/fetch_pkg.sv
// fetch_pkg: types and default constants shared across the Fetch stage.
//   pc_state_t   - PC generator FSM state (BOOT, RUN, HALT)
//   PC_RESET_VEC - default PC loaded at reset
//   PC_EXC_VEC   - default PC loaded on an exception
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0080;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack (LIFO) of DEPTH x WIDTH entries.
// Ports:
//   clk, rst          - clock, async active-high reset (clears pointer/count)
//   push, push_data   - push an address; when full the oldest entry is lost
//   pop               - pop the top entry (ignored while empty)
//   top               - current top-of-stack entry
//   empty, full       - occupancy flags
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;      // next slot to write
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    top_idx;
    logic             do_pop;

    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;

    // The pointer wraps freely, so a push while full simply overwrites the
    // oldest slot; the count saturates at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push && do_pop) begin
            // replace top in place: pointer and count unchanged
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full) cnt <= cnt + CW'(1);
        end else if (do_pop) begin
            ptr <= ptr - PW'(1);
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[do_pop ? top_idx : ptr] <= push_data;
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: Fetch-stage program-counter generator.
// Selects the next fetch address each cycle (exception, redirect, RAS pop,
// hold, sequential increment) and presents it with a valid/ready handshake.
// Optional feature: define PC_GEN_RAS_EN to build the return-address stack.
// Ports:
//   clk, rst                          - clock, async active-high reset
//   fetch_ready, stall                - hold pc when not consumed
//   halt_req                          - enter HALT from RUN
//   redirect_valid, redirect_target   - branch/jump (target aligned to STEP)
//   call_valid                        - redirect is a call (push pc+STEP)
//   ret_valid                         - return (pop RAS if non-empty)
//   exc_valid                         - jump to EXC_VEC
//   pc, pc_valid                      - fetch request
//   misalign                          - one-cycle pulse on misaligned redirect
//   ras_empty, ras_full               - RAS occupancy
module pc_gen
    import fetch_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
    parameter int               RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fetch_ready,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             exc_valid,
    input  logic             call_valid,
    input  logic             ret_valid,
    output logic [WIDTH-1:0] pc,
    output logic             pc_valid,
    output logic             misalign,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] LOW_MASK = STEP_W - WIDTH'(1);

    pc_state_t        state, state_nxt;
    logic [WIDTH-1:0] pc_nxt, pc_inc, redir_pc, ras_top;
    logic             redir_mis, mis_nxt, ras_push, ras_pop;

    assign pc_inc    = pc + STEP_W;
    assign redir_pc  = redirect_target & ~LOW_MASK;
    assign redir_mis = |(redirect_target & LOW_MASK);
    assign pc_valid  = (state == RUN);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        mis_nxt   = 1'b0;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        unique case (state)
            BOOT: state_nxt = RUN;
            RUN: begin
                if (exc_valid) begin
                    pc_nxt = EXC_VEC;
                end else if (redirect_valid) begin
                    pc_nxt   = redir_pc;
                    mis_nxt  = redir_mis;
                    ras_push = call_valid;
                end else begin
                    // The halting edge still honours the normal hold/advance
                    // rules so a request consumed on that edge is not refetched.
                    if (ret_valid && !ras_empty) begin
                        pc_nxt  = ras_top;
                        ras_pop = 1'b1;
                    end else if (!stall && fetch_ready) begin
                        pc_nxt = pc_inc;
                    end
                    if (halt_req) state_nxt = HALT;
                end
            end
            HALT: begin
                if (exc_valid) begin
                    pc_nxt    = EXC_VEC;
                    state_nxt = RUN;
                end else if (redirect_valid) begin
                    pc_nxt    = redir_pc;
                    mis_nxt   = redir_mis;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_VEC;
            misalign <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            misalign <= mis_nxt;
        end
    end

`ifdef PC_GEN_RAS_EN
    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .push_data (pc_inc),
        .pop       (ras_pop),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );
`else
    // Empty stack forever: the return path can never be selected.
    assign ras_top   = '0;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;

    logic unused_ras;
    assign unused_ras = ^{ras_push, ras_pop, call_valid};
`endif

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk, rst;
    logic        fetch_ready, stall, halt_req, redirect_valid, exc_valid;
    logic        call_valid, ret_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic        pc_valid, misalign, ras_empty, ras_full;
    logic [7:0]  pc8;
    logic        pv8, mis8, re8, rf8;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model: 0=boot, 1=run, 2=halt
    int          m_state;
    logic [31:0] m_pc;
    bit          m_mis;
    logic [31:0] m_q[$];

    pc_gen dut (
        .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
        .halt_req(halt_req), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .exc_valid(exc_valid),
        .call_valid(call_valid), .ret_valid(ret_valid), .pc(pc),
        .pc_valid(pc_valid), .misalign(misalign), .ras_empty(ras_empty),
        .ras_full(ras_full)
    );

    // 8-bit instance free-running from 0xF0 to exercise wrap-around
    pc_gen #(.WIDTH(8), .RESET_VEC(8'hF0)) u8 (
        .clk(clk), .rst(rst), .fetch_ready(1'b1), .stall(1'b0),
        .halt_req(1'b0), .redirect_valid(1'b0), .redirect_target(8'h00),
        .exc_valid(1'b0), .call_valid(1'b0), .ret_valid(1'b0), .pc(pc8),
        .pc_valid(pv8), .misalign(mis8), .ras_empty(re8), .ras_full(rf8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        fetch_ready = 1'b1; stall = 1'b0; halt_req = 1'b0;
        redirect_valid = 1'b0; exc_valid = 1'b0; call_valid = 1'b0;
        ret_valid = 1'b0; redirect_target = 32'h0;
    endtask

    task automatic model_reset();
        m_state = 0; m_pc = 32'h0; m_mis = 0; m_q.delete();
    endtask

    // Advance one clock: predict from the current inputs, then step the DUT.
    task automatic tick();
        logic [31:0] npc;
        int          nst;
        bit          nmis;
        npc = m_pc; nst = m_state; nmis = 0;
        if (m_state == 0) begin
            nst = 1;
        end else if (exc_valid) begin
            npc = 32'h80; nst = 1;
        end else if (redirect_valid) begin
            npc  = {redirect_target[31:2], 2'b00};
            nmis = (redirect_target[1:0] != 2'b00);
            nst  = 1;
`ifdef PC_GEN_RAS_EN
            if (m_state == 1 && call_valid) begin
                m_q.push_back(m_pc + 32'd4);
                if (m_q.size() > 4) void'(m_q.pop_front());
            end
`endif
        end else if (m_state == 1) begin
`ifdef PC_GEN_RAS_EN
            if (ret_valid && m_q.size() > 0) npc = m_q.pop_back();
            else
`endif
            if (!stall && fetch_ready) npc = m_pc + 32'd4;
            if (halt_req) nst = 2;
        end
        @(posedge clk);
        m_pc = npc; m_state = nst; m_mis = nmis;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #12;
        n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pc_valid: got %b expected 0", pc_valid); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b expected 0", misalign); end
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ras_empty: got %b expected 1", ras_empty); end
        n_checks++; if (ras_full !== 1'b0) begin n_fail++; $display("FAIL reset_ras_full: got %b expected 0", ras_full); end
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL boot_cycle0_valid: got %b expected 0", pc_valid); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (pc_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, pc_valid); end
            n_checks++; if (pc !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, pc, 32'(i * 4)); end
        end
        n_checks++; if (pc8 !== 8'hFC) begin n_fail++; $display("FAIL w8_pre_wrap: got %h expected fc", pc8); end
    endtask

    task automatic test_wrap();
        tick();
        n_checks++; if (pc8 !== 8'h00) begin n_fail++; $display("FAIL w8_wrap: got %h expected 00", pc8); end
        n_checks++; if (pv8 !== 1'b1) begin n_fail++; $display("FAIL w8_valid: got %b expected 1", pv8); end
        n_checks++; if (pc !== 32'h10) begin n_fail++; $display("FAIL seq_pc_after_wrap: got %h expected 10", pc); end
    endtask

    task automatic test_stall();
        for (int mode = 0; mode < 2; mode++) begin
            redirect_valid = 1'b1; redirect_target = 32'h8;
            tick();
            redirect_valid = 1'b0;
            n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL hold_setup[%0d]: got %h expected 8", mode, pc); end
            if (mode == 0) stall = 1'b1; else fetch_ready = 1'b0;
            for (int i = 0; i < 2; i++) begin
                tick();
                n_checks++; if (pc !== 32'h8) begin n_fail++; $display("FAIL hold[%0d][%0d]: got %h expected 8", mode, i, pc); end
            end
            clear_inputs();
            tick();
            n_checks++; if (pc !== 32'hC) begin n_fail++; $display("FAIL hold_release[%0d]: got %h expected c", mode, pc); end
        end
    endtask

    task automatic test_redirect();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1A;
        tick();
        clear_inputs();
        n_checks++; if (pc !== 32'h18) begin n_fail++; $display("FAIL redir_pc: got %h expected 18", pc); end
        n_checks++; if (misalign !== 1'b1) begin n_fail++; $display("FAIL redir_misalign: got %b expected 1", misalign); end
        tick();
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL misalign_pulse: got %b expected 0", misalign); end
        n_checks++; if (pc !== 32'h1C) begin n_fail++; $display("FAIL redir_next: got %h expected 1c", pc); end
        exc_valid = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h41;
        tick();
        clear_inputs();
        n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL exc_over_redir: got %h expected 80", pc); end
        n_checks++; if (misalign !== 1'b0) begin n_fail++; $display("FAIL exc_misalign: got %b expected 0", misalign); end
    endtask

`ifdef PC_GEN_RAS_EN
    task automatic test_ras();
        logic [31:0] exp;
        redirect_valid = 1'b1; redirect_target = 32'h10;
        tick();
        call_valid = 1'b1; redirect_target = 32'h40;
        tick();
        clear_inputs();
        n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL call_pc: got %h expected 40", pc); end
        n_checks++; if (ras_empty !== 1'b0) begin n_fail++; $display("FAIL call_ras_empty: got %b expected 0", ras_empty); end
        ret_valid = 1'b1;
        tick();
        clear_inputs();
        n_checks++; if (pc !== 32'h14) begin n_fail++; $display("FAIL ret_pc: got %h expected 14", pc); end
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ret_ras_empty: got %b expected 1", ras_empty); end
        for (int i = 1; i <= 5; i++) begin
            redirect_valid = 1'b1; call_valid = 1'b1; redirect_target = 32'(i * 32'h100);
            tick();
        end
        clear_inputs();
        n_checks++; if (ras_full !== 1'b1) begin n_fail++; $display("FAIL ras_full: got %b expected 1", ras_full); end
        n_checks++; if (pc !== 32'h500) begin n_fail++; $display("FAIL call5_pc: got %h expected 500", pc); end
        for (int k = 0; k < 4; k++) begin
            ret_valid = 1'b1;
            tick();
            exp = 32'((4 - k) * 32'h100 + 4);
            n_checks++; if (pc !== exp) begin n_fail++; $display("FAIL ret_seq[%0d]: got %h expected %h", k, pc, exp); end
        end
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL ras_drained: got %b expected 1", ras_empty); end
        tick();
        clear_inputs();
        n_checks++; if (pc !== 32'h108) begin n_fail++; $display("FAIL ret_empty_fall: got %h expected 108", pc); end
    endtask
`else
    task automatic test_ras_off();
        redirect_valid = 1'b1; call_valid = 1'b1; redirect_target = 32'h40;
        tick();
        clear_inputs();
        n_checks++; if (ras_empty !== 1'b1) begin n_fail++; $display("FAIL off_ras_empty: got %b expected 1", ras_empty); end
        ret_valid = 1'b1;
        tick();
        clear_inputs();
        n_checks++; if (pc !== 32'h44) begin n_fail++; $display("FAIL off_ret_ignored: got %h expected 44", pc); end
        n_checks++; if (ras_full !== 1'b0) begin n_fail++; $display("FAIL off_ras_full: got %b expected 0", ras_full); end
    endtask
`endif

    task automatic test_halt();
        logic [31:0] p;
        p = m_pc + 32'd4;   // request consumed on the halting edge
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        n_checks++; if (pc_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid: got %b expected 0", pc_valid); end
        n_checks++; if (pc !== p) begin n_fail++; $display("FAIL halt_pc: got %h expected %h", pc, p); end
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (pc !== p || pc_valid !== 1'b0) begin n_fail++; $display("FAIL halt_frozen[%0d]: got %h/%b expected %h/0", i, pc, pc_valid, p); end
        end
        redirect_valid = 1'b1; redirect_target = 32'h200;
        tick();
        clear_inputs();
        n_checks++; if (pc !== 32'h200 || pc_valid !== 1'b1) begin n_fail++; $display("FAIL halt_exit: got %h/%b expected 200/1", pc, pc_valid); end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (pc !== 32'h0 || pc_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset: got %h/%b expected 0/0", pc, pc_valid); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            fetch_ready     = ($urandom_range(99) < 80);
            stall           = ($urandom_range(99) < 20);
            halt_req        = ($urandom_range(99) < 5);
            redirect_valid  = ($urandom_range(99) < 12);
            exc_valid       = ($urandom_range(99) < 3);
            call_valid      = ($urandom_range(99) < 50);
            ret_valid       = ($urandom_range(99) < 20);
            redirect_target = $urandom;
            tick();
            n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", i, pc, m_pc); end
            n_checks++; if (pc_valid !== (m_state == 1)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, pc_valid, m_state == 1); end
            n_checks++; if (misalign !== m_mis) begin n_fail++; $display("FAIL rnd_misalign[%0d]: got %b expected %b", i, misalign, m_mis); end
            n_checks++; if (ras_empty !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rnd_ras_empty[%0d]: got %b expected %b", i, ras_empty, m_q.size() == 0); end
            n_checks++; if (ras_full !== (m_q.size() == 4)) begin n_fail++; $display("FAIL rnd_ras_full[%0d]: got %b expected %b", i, ras_full, m_q.size() == 4); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_stall();
        test_redirect();
`ifdef PC_GEN_RAS_EN
        test_ras();
`else
        test_ras_off();
`endif
        test_halt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
